// File: rtl/mips_ctl_pkg.sv
// rtl/mips_ctl_pkg.sv - encodings shared by the multicycle MIPS control unit
package mips_ctl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_SLT   = 2'b11
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States whose exit back to FETCH marks a retired instruction.
    function automatic logic is_final_state(state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
               (s == S_IWB)   || (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/alu_control.sv
// rtl/alu_control.sv - maps ALUOp and funct to the ALU control code
module alu_control
    import mips_ctl_pkg::*;
(
    input  alu_op_t     alu_op_i,
    input  logic [5:0]  funct_i,
    output logic [2:0]  alu_ctl_o,
    output logic        funct_ok_o
);

    logic [2:0] funct_ctl;

    // Decode the R-type funct field and select the operation requested by ALUOp.
    always_comb begin
        funct_ok_o = 1'b1;
        funct_ctl  = ALU_ADD;
        case (funct_i)
            FN_ADD:  funct_ctl = ALU_ADD;
            FN_SUB:  funct_ctl = ALU_SUB;
            FN_SLT:  funct_ctl = ALU_SLT;
            FN_AND:  funct_ctl = ALU_AND;
            FN_OR:   funct_ctl = ALU_OR;
            default: funct_ok_o = 1'b0;
        endcase
        case (alu_op_i)
            ALUOP_ADD:   alu_ctl_o = ALU_ADD;
            ALUOP_SUB:   alu_ctl_o = ALU_SUB;
            ALUOP_FUNCT: alu_ctl_o = funct_ctl;
            default:     alu_ctl_o = ALU_SLT;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - Moore control FSM for the multicycle MIPS datapath
module mips_multicycle_control
    import mips_ctl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        BranchNE,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALUCtl,
    output logic        Illegal,
    output logic [3:0]  State,
    output logic [31:0] InstrCount
);

    state_t      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [31:0] count_q;
    logic        retire;
    alu_op_t     alu_op;
    logic        alu_en;
    logic [2:0]  alu_ctl;
    logic        funct_ok;

    alu_control u_alu_control (
        .alu_op_i   (alu_op),
        .funct_i    (funct),
        .alu_ctl_o  (alu_ctl),
        .funct_ok_o (funct_ok)
    );

    // Next-state selection; DECODE also flags opcodes/functs it cannot dispatch.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_SLTI: state_d = S_IEXEC;
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = S_REXEC;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_REXEC:  state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
        retire = is_final_state(state_q) && (state_d == S_FETCH);
    end

    // State, retired-instruction counter and the illegal pulse are registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            count_q   <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_q + {31'd0, retire};
            illegal_q <= illegal_d;
        end
    end

    // Moore datapath controls; FETCH write enables wait for the memory handshake.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        PCSource    = PCSRC_ALU;
        alu_op      = ALUOP_ADD;
        alu_en      = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                alu_en  = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                alu_en  = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                alu_en  = 1'b1;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_REXEC: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
                alu_en  = 1'b1;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                alu_op  = (opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
                alu_en  = 1'b1;
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                alu_op      = ALUOP_SUB;
                alu_en      = 1'b1;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                BranchNE    = opcode[0];
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: ;
        endcase
        if (!reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign ALUCtl     = alu_en ? alu_ctl : 3'b000;
    assign Illegal    = illegal_q & reset;
    assign State      = state_q;
    assign InstrCount = count_q;

endmodule
